// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/MEM/WB stage status in, stall/flush controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_Rs;
    logic [4:0]       IF_ID_Rt;
    logic             IF_ID_UsesRs;
    logic             IF_ID_UsesRt;
    logic             IF_ID_Halt;
    logic             ID_EX_RegWrite;
    logic [4:0]       ID_EX_WriteReg;
    logic             EX_MEM_RegWrite;
    logic [4:0]       EX_MEM_WriteReg;
    logic             MEM_WB_RegWrite;
    logic [4:0]       MEM_WB_WriteReg;
    logic             EX_MEM_Branch;
    logic             EX_MEM_Zero;
    logic             EX_MEM_Jump;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Bubble;
    logic             IF_ID_Flush;
    logic             EX_MEM_Flush;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;
    logic             Halted;
    logic             StallErr;

    // datapath side
    modport master (
        output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_Halt,
               ID_EX_RegWrite, ID_EX_WriteReg, EX_MEM_RegWrite, EX_MEM_WriteReg,
               MEM_WB_RegWrite, MEM_WB_WriteReg, EX_MEM_Branch, EX_MEM_Zero, EX_MEM_Jump,
        input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, EX_MEM_Flush,
               StallCount, FlushCount, Halted, StallErr
    );

    // controller side
    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_Halt,
               ID_EX_RegWrite, ID_EX_WriteReg, EX_MEM_RegWrite, EX_MEM_WriteReg,
               MEM_WB_RegWrite, MEM_WB_WriteReg, EX_MEM_Branch, EX_MEM_Zero, EX_MEM_Jump,
        output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, EX_MEM_Flush,
               StallCount, FlushCount, Halted, StallErr
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: init hold, RAW stall (no forwarding),
// redirect flush, halt freeze, stall watchdog and saturating stall/flush counters.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_INIT  | post-reset hold of PC and IF/ID for INIT_CYCLES cycles
// ST_RUN   | normal issue
// ST_STALL | RAW hazard stall in progress (same decode as RUN)
// ST_HALT  | fetch frozen, pipeline draining; only reset exits
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int MAX_STALL   = 8,
    parameter bit WB_BYPASS   = 1'b0,
    parameter int CNT_W       = 16
) (
    input  logic Clk,
    input  logic Rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_STALL, ST_HALT} state_t;

    localparam logic [3:0]       INIT_LOAD = 4'(INIT_CYCLES - 1);
    localparam logic [7:0]       MAX_RUN   = 8'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       init_cnt_q, init_cnt_d;
    logic [7:0]       stall_run_q, stall_run_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             halted_q, halted_d;
    logic             stall_err_q, stall_err_d;

    logic pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_flush;
    logic redirect, hazard, rs_hit, rt_hit;

    always_comb begin
        redirect = (hz.EX_MEM_Branch & hz.EX_MEM_Zero) | hz.EX_MEM_Jump;
        rs_hit = hz.IF_ID_UsesRs && (hz.IF_ID_Rs != 5'd0) &&
                 ((hz.ID_EX_RegWrite  && (hz.ID_EX_WriteReg  == hz.IF_ID_Rs)) ||
                  (hz.EX_MEM_RegWrite && (hz.EX_MEM_WriteReg == hz.IF_ID_Rs)) ||
                  (!WB_BYPASS && hz.MEM_WB_RegWrite && (hz.MEM_WB_WriteReg == hz.IF_ID_Rs)));
        rt_hit = hz.IF_ID_UsesRt && (hz.IF_ID_Rt != 5'd0) &&
                 ((hz.ID_EX_RegWrite  && (hz.ID_EX_WriteReg  == hz.IF_ID_Rt)) ||
                  (hz.EX_MEM_RegWrite && (hz.EX_MEM_WriteReg == hz.IF_ID_Rt)) ||
                  (!WB_BYPASS && hz.MEM_WB_RegWrite && (hz.MEM_WB_WriteReg == hz.IF_ID_Rt)));
        hazard = rs_hit | rt_hit;
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        stall_run_d  = stall_run_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        stall_err_d  = stall_err_q;

        case (state_q)
            ST_INIT: begin
                id_ex_bubble = 1'b1;
                if (init_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - 4'd1;
                end
            end
            ST_RUN, ST_STALL: begin
                if (redirect) begin
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_flush = 1'b1;
                    stall_run_d  = 8'd0;
                    state_d      = ST_RUN;
                    if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
                end else if (hz.IF_ID_Halt) begin
                    state_d = ST_HALT;
                end else if (hazard) begin
                    id_ex_bubble = 1'b1;
                    if (stall_run_q < MAX_RUN) begin
                        stall_run_d = stall_run_q + 8'd1;
                        state_d     = ST_STALL;
                        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
                    end else begin
                        stall_err_d = 1'b1;
                        state_d     = ST_HALT;
                    end
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    stall_run_d = 8'd0;
                    state_d     = ST_RUN;
                end
            end
            ST_HALT: begin
                id_ex_bubble = 1'b1;
            end
            default: begin
                id_ex_bubble = 1'b1;
                state_d      = ST_INIT;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= INIT_LOAD;
            stall_run_q <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            halted_q    <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            stall_run_q <= stall_run_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            halted_q    <= halted_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign hz.PC_Write     = pc_write;
    assign hz.IF_ID_Write  = if_id_write;
    assign hz.ID_EX_Bubble = id_ex_bubble;
    assign hz.IF_ID_Flush  = if_id_flush;
    assign hz.EX_MEM_Flush = ex_mem_flush;
    assign hz.StallCount   = stall_cnt_q;
    assign hz.FlushCount   = flush_cnt_q;
    assign hz.Halted       = halted_q;
    assign hz.StallErr     = stall_err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default config, MAX_STALL=4 watchdog, CNT_W=4 saturation.
module tb_pipeline_hazard_ctrl;
    logic Clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) if0 ();
    pipeline_hazard_ctrl_if #(.CNT_W(16)) if1 ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  if2 ();

    pipeline_hazard_ctrl #(.INIT_CYCLES(2), .MAX_STALL(8), .WB_BYPASS(1'b0), .CNT_W(16))
        u_dut0 (.Clk(Clk), .Rst(rst_n), .hz(if0));
    pipeline_hazard_ctrl #(.INIT_CYCLES(2), .MAX_STALL(4), .WB_BYPASS(1'b0), .CNT_W(16))
        u_dut1 (.Clk(Clk), .Rst(rst_n), .hz(if1));
    pipeline_hazard_ctrl #(.INIT_CYCLES(2), .MAX_STALL(255), .WB_BYPASS(1'b0), .CNT_W(4))
        u_dut2 (.Clk(Clk), .Rst(rst_n), .hz(if2));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        {if0.IF_ID_Rs, if0.IF_ID_Rt, if0.IF_ID_UsesRs, if0.IF_ID_UsesRt, if0.IF_ID_Halt,
         if0.ID_EX_RegWrite, if0.ID_EX_WriteReg, if0.EX_MEM_RegWrite, if0.EX_MEM_WriteReg,
         if0.MEM_WB_RegWrite, if0.MEM_WB_WriteReg, if0.EX_MEM_Branch, if0.EX_MEM_Zero,
         if0.EX_MEM_Jump} = '0;
        {if1.IF_ID_Rs, if1.IF_ID_Rt, if1.IF_ID_UsesRs, if1.IF_ID_UsesRt, if1.IF_ID_Halt,
         if1.ID_EX_RegWrite, if1.ID_EX_WriteReg, if1.EX_MEM_RegWrite, if1.EX_MEM_WriteReg,
         if1.MEM_WB_RegWrite, if1.MEM_WB_WriteReg, if1.EX_MEM_Branch, if1.EX_MEM_Zero,
         if1.EX_MEM_Jump} = '0;
        {if2.IF_ID_Rs, if2.IF_ID_Rt, if2.IF_ID_UsesRs, if2.IF_ID_UsesRt, if2.IF_ID_Halt,
         if2.ID_EX_RegWrite, if2.ID_EX_WriteReg, if2.EX_MEM_RegWrite, if2.EX_MEM_WriteReg,
         if2.MEM_WB_RegWrite, if2.MEM_WB_WriteReg, if2.EX_MEM_Branch, if2.EX_MEM_Zero,
         if2.EX_MEM_Jump} = '0;

        repeat (2) @(negedge Clk);
        #1;
        check_val("rst_pc",     if0.PC_Write, 0);
        check_val("rst_bubble", if0.ID_EX_Bubble, 1);
        check_val("rst_stall",  if0.StallCount, 0);
        check_val("rst_flush",  if0.FlushCount, 0);
        check_val("rst_halted", if0.Halted, 0);
        check_val("rst_err",    if0.StallErr, 0);

        // init hold: exactly two cycles with PC frozen
        @(negedge Clk);
        rst_n = 1'b1;
        #1 check_val("init_c1_pc", if0.PC_Write, 0);
        @(negedge Clk);
        #1 check_val("init_c2_pc", if0.PC_Write, 0);
        check_val("init_c2_ifid", if0.IF_ID_Write, 0);
        @(negedge Clk);
        #1 check_val("run_pc", if0.PC_Write, 1);
        check_val("run_ifid",   if0.IF_ID_Write, 1);
        check_val("run_bubble", if0.ID_EX_Bubble, 0);
        check_val("run_stallc", if0.StallCount, 0);

        // producer of $8 walks EX -> MEM -> WB
        if0.IF_ID_Rs = 5'd8; if0.IF_ID_UsesRs = 1'b1;
        if0.ID_EX_RegWrite = 1'b1; if0.ID_EX_WriteReg = 5'd8;
        #1 check_val("raw_ex_pc", if0.PC_Write, 0);
        check_val("raw_ex_bub", if0.ID_EX_Bubble, 1);
        @(negedge Clk);
        if0.ID_EX_RegWrite = 1'b0; if0.EX_MEM_RegWrite = 1'b1; if0.EX_MEM_WriteReg = 5'd8;
        #1 check_val("raw_mem_pc", if0.PC_Write, 0);
        check_val("raw_mem_bub", if0.ID_EX_Bubble, 1);
        @(negedge Clk);
        if0.EX_MEM_RegWrite = 1'b0; if0.MEM_WB_RegWrite = 1'b1; if0.MEM_WB_WriteReg = 5'd8;
        #1 check_val("raw_wb_pc", if0.PC_Write, 0);
        check_val("raw_wb_bub", if0.ID_EX_Bubble, 1);
        @(negedge Clk);
        if0.MEM_WB_RegWrite = 1'b0;
        #1 check_val("raw_done_pc", if0.PC_Write, 1);
        check_val("raw_done_bub", if0.ID_EX_Bubble, 0);
        check_val("raw_stallc",   if0.StallCount, 3);

        if0.IF_ID_Rs = 5'd0; if0.ID_EX_RegWrite = 1'b1; if0.ID_EX_WriteReg = 5'd0;
        #1 check_val("r0_nostall", if0.PC_Write, 1);
        if0.IF_ID_Rs = 5'd8; if0.ID_EX_WriteReg = 5'd8; if0.IF_ID_UsesRs = 1'b0;
        #1 check_val("unused_nostall", if0.PC_Write, 1);

        @(negedge Clk);
        if0.ID_EX_RegWrite = 1'b0;
        if0.IF_ID_Rt = 5'd5; if0.IF_ID_UsesRt = 1'b1;
        if0.EX_MEM_RegWrite = 1'b1; if0.EX_MEM_WriteReg = 5'd5;
        #1 check_val("rt_stall", if0.PC_Write, 0);

        // redirect beats the still-present rt hazard
        @(negedge Clk);
        if0.EX_MEM_Branch = 1'b1; if0.EX_MEM_Zero = 1'b1;
        #1 check_val("br_pc",     if0.PC_Write, 1);
        check_val("br_ifflush",   if0.IF_ID_Flush, 1);
        check_val("br_exflush",   if0.EX_MEM_Flush, 1);
        check_val("br_bubble",    if0.ID_EX_Bubble, 1);
        check_val("br_stallc",    if0.StallCount, 4);
        @(negedge Clk);
        if0.EX_MEM_Branch = 1'b0; if0.EX_MEM_Zero = 1'b0; if0.EX_MEM_Jump = 1'b1;
        #1 check_val("br_flushc", if0.FlushCount, 1);
        check_val("br_stallc2",   if0.StallCount, 4);
        check_val("jmp_ifflush",  if0.IF_ID_Flush, 1);
        check_val("jmp_exflush",  if0.EX_MEM_Flush, 1);
        check_val("jmp_pc",       if0.PC_Write, 1);
        @(negedge Clk);
        if0.EX_MEM_Jump = 1'b0; if0.EX_MEM_Branch = 1'b1; if0.EX_MEM_Zero = 1'b0;
        if0.IF_ID_UsesRt = 1'b0; if0.EX_MEM_RegWrite = 1'b0;
        #1 check_val("jmp_flushc", if0.FlushCount, 2);
        check_val("nt_ifflush",    if0.IF_ID_Flush, 0);
        check_val("nt_exflush",    if0.EX_MEM_Flush, 0);
        check_val("nt_pc",         if0.PC_Write, 1);

        // halt: instruction proceeds, then everything frozen
        @(negedge Clk);
        if0.EX_MEM_Branch = 1'b0; if0.IF_ID_Halt = 1'b1;
        #1 check_val("halt_bubble", if0.ID_EX_Bubble, 0);
        check_val("halt_pc",        if0.PC_Write, 0);
        check_val("halt_pre",       if0.Halted, 0);
        @(negedge Clk);
        if0.IF_ID_Halt = 1'b0; if0.EX_MEM_Jump = 1'b1;
        if0.IF_ID_UsesRs = 1'b1; if0.ID_EX_RegWrite = 1'b1;
        #1 check_val("halted",      if0.Halted, 1);
        check_val("halted_pc",      if0.PC_Write, 0);
        check_val("halted_flush",   if0.IF_ID_Flush, 0);
        check_val("halted_bubble",  if0.ID_EX_Bubble, 1);
        @(negedge Clk);
        #1 check_val("halted_flushc", if0.FlushCount, 2);
        check_val("halted_stallc",    if0.StallCount, 4);
        check_val("halted_hold",      if0.Halted, 1);

        // watchdog with MAX_STALL=4
        @(negedge Clk);
        if1.IF_ID_Rs = 5'd3; if1.IF_ID_UsesRs = 1'b1;
        if1.ID_EX_RegWrite = 1'b1; if1.ID_EX_WriteReg = 5'd3;
        #1 check_val("wd_pc", if1.PC_Write, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clk);
            #1 check_val("wd_noerr", if1.StallErr, 0);
            check_val("wd_nohalt", if1.Halted, 0);
        end
        check_val("wd_stallc", if1.StallCount, 4);
        @(negedge Clk);
        #1 check_val("wd_err", if1.StallErr, 1);
        check_val("wd_halted", if1.Halted, 1);
        check_val("wd_pc_hold", if1.PC_Write, 0);

        // CNT_W=4 saturation
        @(negedge Clk);
        if2.IF_ID_Rt = 5'd9; if2.IF_ID_UsesRt = 1'b1;
        if2.MEM_WB_RegWrite = 1'b1; if2.MEM_WB_WriteReg = 5'd9;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            #1;
            if (i >= 14) check_val("sat_stallc", if2.StallCount, (i < 15) ? i : 15);
        end
        check_val("sat_pc", if2.PC_Write, 0);

        // asynchronous reset mid-stall, away from any clock edge
        #1 rst_n = 1'b0;
        #1 check_val("arst_pc", if2.PC_Write, 0);
        check_val("arst_ifid",   if2.IF_ID_Write, 0);
        check_val("arst_bubble", if2.ID_EX_Bubble, 1);
        check_val("arst_stallc", if2.StallCount, 0);
        check_val("arst_halt0",  if0.Halted, 0);
        check_val("arst_err1",   if1.StallErr, 0);
        check_val("arst_halt1",  if1.Halted, 0);
        @(negedge Clk);
        rst_n = 1'b1;
        #1 check_val("rerun_init_pc", if2.PC_Write, 0);
        check_val("rerun_init_bub", if2.ID_EX_Bubble, 1);
        @(negedge Clk);
        @(negedge Clk);
        #1 check_val("rerun_stall", if2.PC_Write, 0);
        check_val("rerun_stallc", if2.StallCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline. Holds the pipeline after reset, detects RAW hazards in ID (the datapath has no forwarding), and stalls PC and IF/ID while injecting bubbles into ID/EX. Flushes wrong-path stages when a taken branch or jump resolves in MEM. Freezes fetch on halt and keeps saturating stall and flush performance counters.

Parameters:
INIT_CYCLES, 2, cycles PC/IF_ID are held after reset release (1..15)
MAX_STALL, 8, consecutive stall cycles tolerated before watchdog halt (1..255)
WB_BYPASS, 0, 1 = register file is write-before-read, so MEM/WB matches do not stall
CNT_W, 16, width of performance counters

Ports:
Clk  in  1  pipeline clock
Rst  in  1  reset
IF_ID_Rs  in  5  ID source register rs
IF_ID_Rt  in  5  ID source register rt
IF_ID_UsesRs  in  1  ID instruction reads rs
IF_ID_UsesRt  in  1  ID instruction reads rt
IF_ID_Halt  in  1  ID instruction is halt
ID_EX_RegWrite  in  1  EX-stage instruction writes a register
ID_EX_WriteReg  in  5  EX destination (RegDst mux output)
EX_MEM_RegWrite  in  1  MEM-stage instruction writes a register
EX_MEM_WriteReg  in  5  MEM destination
MEM_WB_RegWrite  in  1  WB-stage instruction writes a register
MEM_WB_WriteReg  in  5  WB destination
EX_MEM_Branch  in  1  MEM-stage branch
EX_MEM_Zero  in  1  MEM-stage ALU zero
EX_MEM_Jump  in  1  MEM-stage jump
PC_Write  out  1  PC load enable
IF_ID_Write  out  1  IF/ID load enable
ID_EX_Bubble  out  1  zero ID/EX control fields this cycle
IF_ID_Flush  out  1  clear IF/ID
EX_MEM_Flush  out  1  clear EX/MEM control fields
StallCount  out  CNT_W  stall cycles (saturating)
FlushCount  out  CNT_W  redirect events (saturating)
Halted  out  1  controller is in HALT
StallErr  out  1  watchdog fired

Behaviour:
- Reset: Rst is asynchronous and active-low. While Rst=0: state=INIT, init counter=INIT_CYCLES-1, stall run=0, counters=0, Halted=0, StallErr=0.
- Control outputs are combinational from state and inputs. Counters, Halted and StallErr are registered.
- redirect = (EX_MEM_Branch & EX_MEM_Zero) | EX_MEM_Jump.
- hazard: a source register matches a destination when all of these hold:
  - the source is used (UsesRs for rs, UsesRt for rt)
  - the source is nonzero
  - the destination equals the source and its RegWrite=1, for ID_EX or EX_MEM, or for MEM_WB when WB_BYPASS=0.
- INIT:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, flushes=0.
  - Counter decrements each cycle. At 0, go to RUN. INIT lasts exactly INIT_CYCLES cycles.
  - redirect, hazard and halt are ignored.
- RUN/STALL priority, top to bottom:
  - redirect: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Flush=1. FlushCount+1. Stall run cleared. Next state RUN. Redirect beats a simultaneous hazard or halt.
  - IF_ID_Halt: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0 (the halt instruction proceeds). Next state HALT.
  - hazard with stall run < MAX_STALL: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. StallCount+1, stall run+1. Next state STALL.
  - hazard with stall run = MAX_STALL: same outputs as a stall. StallErr set, next state HALT.
  - otherwise: PC_Write=1, IF_ID_Write=1, everything else 0. Stall run cleared. Next state RUN.
- HALT:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, flushes=0. The pipeline drains.
  - Halted=1 from the first cycle in HALT.
  - Inputs are ignored. Only reset exits HALT.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-redirect returns to INIT immediately. Outputs take INIT values in the same cycle.

Test Plan:
- Reset released, pipeline idle, INIT_CYCLES=2 -> PC_Write=0 for exactly 2 cycles, then 1. Counters 0.
- ID reads rs=$8 (UsesRs=1), ID_EX_WriteReg=8, RegWrite=1, WB_BYPASS=0; the instruction then moves EX->MEM->WB -> 3 stall cycles, ID_EX_Bubble=1 each, StallCount=3, then PC_Write=1. Rs=$0 in the same setup -> no stall.
- Hazard and EX_MEM_Branch=1, Zero=1 in the same cycle -> IF_ID_Flush=1, EX_MEM_Flush=1, PC_Write=1, FlushCount=1, StallCount unchanged. EX_MEM_Jump=1 behaves the same. Branch=1 with Zero=0 -> no flush.
- IF_ID_Halt=1 -> that cycle has ID_EX_Bubble=0. Next cycle Halted=1, PC_Write=0. Later redirect or hazard inputs have no effect.
- Hazard held constant with MAX_STALL=4 -> 4 stall cycles, StallErr=1 on the 5th edge, Halted=1.
- CNT_W=4 preload via 20 stall cycles with MAX_STALL=255 -> StallCount holds at 15. Rst pulsed low mid-stall -> all outputs return to INIT values asynchronously.
